frame_stream_ctrl: RTL and testbench
====================================

Name: frame_stream_ctrl

Overview:
- Parametrised frame sequencer sitting between the sample buffer and the transform core (DIT/IFFT chain).
- Accepts an NCH-channel sample frame over a valid/ready handshake and launches the core with a start/done handshake.
- Scales and saturates the core results, then presents them downstream over valid/ready.
- Counts delivered samples against a programmable load size and raises a sticky done flag, replacing the fixed-count, fixed-divide, free-running flow of the previous generation.

Parameters:
- NCH, 8, channels (samples) per frame; valid range 1..16.
- SW, 16, sample width in and out.
- CW, 17, core data width; must satisfy CW > SW.
- SHIFT, 3, right-shift applied to core results (divide by 2^SHIFT).
- CNTW, 32, sample-counter and load-size width.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- flag_clear  in  1  synchronous clear of sample_count and wav_done.
- load_size  in  CNTW  number of samples for one complete file; 0 means unlimited.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept an input frame.
- in_data  in  NCH*SW  input frame; channel k occupies bits [k*SW +: SW].
- core_start  out  1  one-cycle start pulse to the core.
- core_data  out  NCH*CW  latched frame, each channel zero-extended to CW.
- core_done  in  1  core result valid, single-cycle pulse.
- core_result  in  NCH*CW  core outputs, sampled only on core_done.
- out_valid  out  1  output frame valid.
- out_ready  in  1  downstream accepts the output frame.
- out_data  out  NCH*SW  scaled output frame.
- sample_count  out  CNTW  samples delivered since reset or clear.
- wav_done  out  1  sticky: load_size samples have been delivered.

Behaviour:
- Reset (n_rst low, asynchronous) values:
  - state = IDLE.
  - in_ready, core_start, out_valid, wav_done = 0.
  - out_data, core_data, sample_count = 0.
- Reset mid-frame discards the frame; a core_done arriving after reset is ignored.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE:
  - in_ready = !wav_done (registered-state-derived, no combinational path from in_valid).
  - On in_valid && in_ready: latch in_data into core_data, go to LAUNCH.
- LAUNCH:
  - core_start = 1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On core_done: register the scaled core_result into out_data, go to HOLD.
  - No timeout: the block waits indefinitely.
  - A core_done outside WAIT is ignored.
- HOLD:
  - out_valid = 1; out_data is held stable until the handshake.
  - On out_ready: return to IDLE and add NCH to sample_count.
- Throughput:
  - Best-case latency from input handshake to out_valid is 3 cycles, given core_done in the first WAIT cycle.
  - At most one frame is in flight.
- Scaling, per channel, unsigned:
  - r = core_result_k >> SHIFT.
  - If r > 2^SW-1, out = 2^SW-1 (saturate); otherwise out = r[SW-1:0].
  - Example: 17'h1FFFF >> 3 = 16383 passes; with SHIFT=0, 17'h1FFFF saturates to 16'hFFFF.
- Counter and done:
  - On an output handshake, next_count = sample_count + NCH.
  - If load_size != 0 and next_count >= load_size, set wav_done in the same cycle the count updates.
  - wav_done stays set until flag_clear or reset.
  - The counter saturates at 2^CNTW-1 and never wraps.
  - The overshoot case (load_size not a multiple of NCH) still sets wav_done.
- flag_clear:
  - Next cycle: sample_count = 0, wav_done = 0.
  - Has priority over a simultaneous output handshake; that frame is still delivered, but its count is dropped.
  - Does not change FSM state.
- load_size is sampled each cycle; changing it mid-file takes effect at the next handshake.

Decomposition:
- Package frame_stream_pkg:
  - State enum type: IDLE, LAUNCH, WAIT, HOLD.
  - Channel-slicing localparams.
  - Constant SAT_MAX = 2^SW-1.
- Sub-module frame_scaler: combinational, per-channel shift-and-saturate, instantiated once over the NCH*CW bus, parameters CW, SW, SHIFT, NCH.

Test Plan:
- Reset then single frame, in_data all channels 16'h0100, core echoes core_data ×8 with done 1 cycle after start:
  - required: out_data channels = 16'h0100.
  - required: out_valid 3 cycles after the input handshake.
  - required: sample_count = 8.
- Saturation, SHIFT=0: core_result channel 0 = 17'h1FFFF, channel 1 = 17'h0FFFF:
  - required: out channel 0 = 16'hFFFF, channel 1 = 16'hFFFF.
  - With SHIFT=3, required: out channel 0 = 16'h3FFF.
- load_size = 20, NCH=8, three frames:
  - required: wav_done rises with the third output handshake, count = 24.
  - required: in_ready stays 0 afterwards.
  - flag_clear, required: count 0, wav_done 0, in_ready 1.
- Backpressure: out_ready held low 10 cycles in HOLD:
  - required: out_data stable, no count change, in_ready 0.
  - Stray core_done pulse during HOLD: ignored.
- flag_clear in the same cycle as an output handshake with count = 16:
  - required: count = 0 next cycle (not 8), wav_done 0.
- n_rst asserted during WAIT:
  - required: all outputs at reset values immediately.
  - Late core_done: ignored.
  - Next frame completes normally.

Source files
------------

// File: rtl/frame_stream_pkg.sv
// frame_stream_pkg: shared types and constants for the frame sequencer.
//   state_e     : sequencer state (idle, launch core, wait for core, hold output).
//   *_DEF       : default frame geometry used by the top-level parameters.
//   SAT_MAX     : largest output sample value for the default sample width.
//   ch_lsb()    : LSB position of channel k in a packed bus of w-bit lanes.
package frame_stream_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StWait,
      StHold
   } state_e;

   localparam int unsigned NCH_DEF  = 8;
   localparam int unsigned NCH_MAX  = 16;
   localparam int unsigned SW_DEF   = 16;
   localparam int unsigned CW_DEF   = 17;
   localparam int unsigned CNTW_DEF = 32;
   localparam int unsigned SAT_MAX  = (1 << SW_DEF) - 1;

   function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/frame_stream_ctrl_scaler.sv
// frame_scaler: per-channel unsigned shift-and-saturate of the core results.
//   result : NCH*CW  core outputs, channel k at [k*CW +: CW].
//   scaled : NCH*SW  (result_k >> SHIFT) clamped to 2^SW-1.
module frame_scaler
   import frame_stream_pkg::*;
#(
   parameter int unsigned CW    = CW_DEF,
   parameter int unsigned SW    = SW_DEF,
   parameter int unsigned SHIFT = 3,
   parameter int unsigned NCH   = NCH_DEF
) (
   input  logic [NCH*CW-1:0] result,
   output logic [NCH*SW-1:0] scaled
);

   // All-ones in the low SW bits, compared at core width so the clamp is exact.
   localparam logic [CW-1:0] SAT = CW'({SW{1'b1}});

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [CW-1:0] shifted;
      assign shifted = result[ch_lsb(k, CW) +: CW] >> SHIFT;
      assign scaled[ch_lsb(k, SW) +: SW] = (shifted > SAT) ? SAT[SW-1:0] : shifted[SW-1:0];
   end

endmodule

// File: rtl/frame_stream_ctrl.sv
// frame_stream_ctrl: one-frame-in-flight sequencer between sample buffer and transform core.
//   clk, n_rst         : clock, asynchronous active-low reset.
//   flag_clear         : synchronous clear of sample_count and wav_done.
//   load_size          : samples per file, 0 = unlimited.
//   in_valid/in_ready  : input frame handshake, in_data NCH*SW.
//   core_start         : one-cycle launch pulse; core_data holds the zero-extended frame.
//   core_done          : result strobe, core_result sampled only while waiting.
//   out_valid/out_ready: output frame handshake, out_data NCH*SW scaled results.
//   sample_count       : samples delivered (saturating); wav_done sticky completion.
module frame_stream_ctrl
   import frame_stream_pkg::*;
#(
   parameter int unsigned NCH   = NCH_DEF,
   parameter int unsigned SW    = SW_DEF,
   parameter int unsigned CW    = CW_DEF,
   parameter int unsigned SHIFT = 3,
   parameter int unsigned CNTW  = CNTW_DEF
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              flag_clear,
   input  logic [CNTW-1:0]   load_size,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [NCH*SW-1:0] in_data,
   output logic              core_start,
   output logic [NCH*CW-1:0] core_data,
   input  logic              core_done,
   input  logic [NCH*CW-1:0] core_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NCH*SW-1:0] out_data,
   output logic [CNTW-1:0]   sample_count,
   output logic              wav_done
);

   state_e            state_q, state_d;
   logic              in_ready_q, core_start_q, out_valid_q;
   logic              wav_done_q, wav_done_d;
   logic [CNTW-1:0]   count_q, count_d;
   logic [CNTW:0]     count_sum;
   logic [NCH*CW-1:0] core_data_q, in_ext;
   logic [NCH*SW-1:0] out_data_q, scaled;
   logic              in_hs, out_hs;

   for (genvar k = 0; k < NCH; k++) begin : g_ext
      assign in_ext[ch_lsb(k, CW) +: CW] = CW'(in_data[ch_lsb(k, SW) +: SW]);
   end

   frame_scaler #(
      .CW    (CW),
      .SW    (SW),
      .SHIFT (SHIFT),
      .NCH   (NCH)
   ) u_scaler (
      .result (core_result),
      .scaled (scaled)
   );

   assign in_hs  = (state_q == StIdle) && in_valid && in_ready_q;
   assign out_hs = (state_q == StHold) && out_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (in_hs)     state_d = StLaunch;
         StLaunch:                state_d = StWait;
         StWait:   if (core_done) state_d = StHold;
         StHold:   if (out_ready) state_d = StIdle;
         default:                 state_d = StIdle;
      endcase
   end

   // Unsaturated sum keeps the load_size compare correct even when the counter clamps.
   assign count_sum = {1'b0, count_q} + (CNTW+1)'(NCH);

   always_comb begin
      count_d    = count_q;
      wav_done_d = wav_done_q;
      if (flag_clear) begin
         // Clear wins: a frame delivered this cycle is not counted.
         count_d    = '0;
         wav_done_d = 1'b0;
      end else if (out_hs) begin
         count_d = count_sum[CNTW] ? '1 : count_sum[CNTW-1:0];
         if ((load_size != '0) && (count_sum >= {1'b0, load_size})) wav_done_d = 1'b1;
      end
   end

   // Handshake outputs are registered from next-state so nothing is combinational
   // from the inputs and all of them read 0 while in reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= StIdle;
         in_ready_q   <= 1'b0;
         core_start_q <= 1'b0;
         out_valid_q  <= 1'b0;
         wav_done_q   <= 1'b0;
         count_q      <= '0;
         core_data_q  <= '0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= (state_d == StIdle) && !wav_done_d;
         core_start_q <= (state_d == StLaunch);
         out_valid_q  <= (state_d == StHold);
         wav_done_q   <= wav_done_d;
         count_q      <= count_d;
         if (in_hs) core_data_q <= in_ext;
         if ((state_q == StWait) && core_done) out_data_q <= scaled;
      end
   end

   assign in_ready     = in_ready_q;
   assign core_start   = core_start_q;
   assign core_data    = core_data_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign sample_count = count_q;
   assign wav_done     = wav_done_q;

endmodule

// File: tb/tb_frame_stream_ctrl.sv
module tb_frame_stream_ctrl;

   localparam int unsigned NCH  = 8;
   localparam int unsigned SW   = 16;
   localparam int unsigned CW   = 17;
   localparam int unsigned CNTW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              n_rst, flag_clear, in_valid, out_ready;
   logic [CNTW-1:0]   load_size;
   logic [NCH*SW-1:0] in_data;
   logic              core_done;
   logic [NCH*CW-1:0] core_result;

   logic              in_ready, core_start, out_valid, wav_done;
   logic [NCH*CW-1:0] core_data;
   logic [NCH*SW-1:0] out_data;
   logic [CNTW-1:0]   sample_count;

   logic              in_ready_s0, core_start_s0, out_valid_s0, wav_done_s0;
   logic [NCH*CW-1:0] core_data_s0;
   logic [NCH*SW-1:0] out_data_s0;
   logic [CNTW-1:0]   sample_count_s0;

   frame_stream_ctrl #(.NCH(NCH), .SW(SW), .CW(CW), .SHIFT(3), .CNTW(CNTW)) u_dut (
      .clk(clk), .n_rst(n_rst), .flag_clear(flag_clear), .load_size(load_size),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .core_start(core_start), .core_data(core_data), .core_done(core_done),
      .core_result(core_result), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .sample_count(sample_count), .wav_done(wav_done)
   );

   // Second instance with SHIFT=0 on identical stimulus, for the saturation path.
   frame_stream_ctrl #(.NCH(NCH), .SW(SW), .CW(CW), .SHIFT(0), .CNTW(CNTW)) u_dut_s0 (
      .clk(clk), .n_rst(n_rst), .flag_clear(flag_clear), .load_size(load_size),
      .in_valid(in_valid), .in_ready(in_ready_s0), .in_data(in_data),
      .core_start(core_start_s0), .core_data(core_data_s0), .core_done(core_done),
      .core_result(core_result), .out_valid(out_valid_s0), .out_ready(out_ready),
      .out_data(out_data_s0), .sample_count(sample_count_s0), .wav_done(wav_done_s0)
   );

   // Core stand-in: done one cycle after start, result either echo x8 or a set value.
   logic              core_en, echo, stray_req;
   logic [NCH*CW-1:0] core_resp;

   always @(posedge clk) begin
      core_done <= (core_en && core_start) || stray_req;
      for (int k = 0; k < NCH; k++)
         core_result[k*CW +: CW] <= echo ? (core_data[k*CW +: CW] << 3) : core_resp[k*CW +: CW];
   end

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned model_count;
   logic        model_done;
   int unsigned model_load;

   typedef struct {
      logic [CW-1:0] r0, r1;
      logic [SW-1:0] e3_0, e3_1, e0_0, e0_1;
   } vec_t;
   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [SW-1:0] scale_ch(input logic [CW-1:0] r, input int sh);
      int unsigned v;
      v = r;
      v = v / (32'd1 << sh);
      if (v > 65535) v = 65535;
      return v[SW-1:0];
   endfunction

   function automatic logic [NCH*SW-1:0] exp_frame(input logic [NCH*CW-1:0] res, input int sh);
      logic [NCH*SW-1:0] f;
      for (int k = 0; k < NCH; k++) f[k*SW +: SW] = scale_ch(res[k*CW +: CW], sh);
      return f;
   endfunction

   function automatic logic [NCH*SW-1:0] rep_sw(input logic [SW-1:0] v);
      logic [NCH*SW-1:0] f;
      for (int k = 0; k < NCH; k++) f[k*SW +: SW] = v;
      return f;
   endfunction

   function automatic logic [NCH*CW-1:0] rep_cw(input logic [CW-1:0] v);
      logic [NCH*CW-1:0] f;
      for (int k = 0; k < NCH; k++) f[k*CW +: CW] = v;
      return f;
   endfunction

   function automatic logic [NCH*CW-1:0] zext(input logic [NCH*SW-1:0] d);
      logic [NCH*CW-1:0] f;
      for (int k = 0; k < NCH; k++) f[k*CW +: CW] = {1'b0, d[k*SW +: SW]};
      return f;
   endfunction

   task automatic send_frame(input logic [NCH*SW-1:0] din, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin tick(); w++; end
      if (!in_ready) begin
         check("in_ready_timeout", in_ready, 1);
         lat = -1;
         return;
      end
      in_valid = 1'b1;
      in_data  = din;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin tick(); lat++; end
      if (!out_valid) check("out_valid_timeout", out_valid, 1);
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      model_count = model_count + NCH;
      if (model_load != 0 && model_count >= model_load) model_done = 1'b1;
   endtask

   task automatic do_clear();
      flag_clear = 1'b1;
      tick();
      flag_clear = 1'b0;
      model_count = 0;
      model_done  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int                lat;
      logic [NCH*SW-1:0] snap, din;
      logic [NCH*CW-1:0] res;

      vecs[0] = '{17'h1FFFF, 17'h0FFFF, 16'h3FFF, 16'h1FFF, 16'hFFFF, 16'hFFFF};
      vecs[1] = '{17'h00800, 17'h00007, 16'h0100, 16'h0000, 16'h0800, 16'h0007};
      vecs[2] = '{17'h10000, 17'h00000, 16'h2000, 16'h0000, 16'hFFFF, 16'h0000};
      vecs[3] = '{17'h0FFFF, 17'h1FFF8, 16'h1FFF, 16'h3FFF, 16'hFFFF, 16'hFFFF};

      n_rst = 1'b0; flag_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      load_size = '0; in_data = '0; core_en = 1'b1; echo = 1'b0; stray_req = 1'b0;
      core_resp = '0; model_count = 0; model_done = 1'b0; model_load = 0;

      // Reset values
      #12;
      check("rst_in_ready", in_ready, 0);
      check("rst_core_start", core_start, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_wav_done", wav_done, 0);
      check("rst_out_data", out_data, 0);
      check("rst_core_data", core_data, 0);
      check("rst_count", sample_count, 0);
      tick();
      n_rst = 1'b1;
      tick();
      check("idle_in_ready", in_ready, 1);

      // Single echoed frame
      echo = 1'b1;
      send_frame(rep_sw(16'h0100), lat);
      check("t1_latency", lat, 3);
      check("t1_out", out_data, rep_sw(16'h0100));
      check("t1_out_s0", out_data_s0, rep_sw(16'h0800));
      check("t1_in_ready_busy", in_ready, 0);
      accept();
      check("t1_count", sample_count, model_count);
      echo = 1'b0;

      // Table-driven scaling / saturation vectors
      foreach (vecs[i]) begin
         core_resp = rep_cw(vecs[i].r0);
         core_resp[CW +: CW] = vecs[i].r1;
         send_frame(rep_sw(16'h5A5A), lat);
         check("vec_ch0_s3", out_data[SW-1:0], vecs[i].e3_0);
         check("vec_ch1_s3", out_data[2*SW-1:SW], vecs[i].e3_1);
         check("vec_ch0_s0", out_data_s0[SW-1:0], vecs[i].e0_0);
         check("vec_ch1_s0", out_data_s0[2*SW-1:SW], vecs[i].e0_1);
         accept();
         check("vec_count", sample_count, model_count);
      end

      // Backpressure in HOLD with a stray core_done
      core_resp = rep_cw(17'h0ABCD);
      send_frame(rep_sw(16'h1111), lat);
      check("bp_out", out_data, exp_frame(core_resp, 3));
      snap = out_data;
      core_resp = rep_cw(17'h1F00F);
      for (int i = 0; i < 10; i++) begin
         stray_req = (i == 4);
         tick();
         stray_req = 1'b0;
         check("bp_stable", out_data, snap);
         check("bp_count", sample_count, model_count);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
      end
      accept();
      check("bp_count_after", sample_count, model_count);

      // flag_clear coincident with an output handshake
      do_clear();
      check("clr_count", sample_count, 0);
      for (int i = 0; i < 2; i++) begin send_frame(rep_sw(16'h0002), lat); accept(); end
      check("clr_count16", sample_count, 16);
      send_frame(rep_sw(16'h0003), lat);
      out_ready = 1'b1; flag_clear = 1'b1;
      tick();
      out_ready = 1'b0; flag_clear = 1'b0;
      model_count = 0;
      check("clr_hs_count", sample_count, 0);
      check("clr_hs_done", wav_done, 0);
      check("clr_hs_delivered", out_valid, 0);

      // load_size = 20 over three frames
      load_size = 20; model_load = 20;
      for (int i = 0; i < 3; i++) begin
         send_frame(rep_sw(16'h0040), lat);
         accept();
         check("ls_done", wav_done, model_done);
         check("ls_count", sample_count, model_count);
      end
      check("ls_done_final", wav_done, 1);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ls_in_ready_low", in_ready, 0);
         check("ls_no_start", core_start, 0);
      end
      in_valid = 1'b0;
      do_clear();
      check("ls_clr_count", sample_count, 0);
      check("ls_clr_done", wav_done, 0);
      check("ls_clr_ready", in_ready, 1);

      // Randomised frames against the reference model
      model_load = $urandom_range(0, 120);
      if (model_load < 8) model_load = 0;
      load_size = model_load;
      for (int i = 0; i < 25; i++) begin
         if (model_done) begin
            check("rnd_done_blocks", in_ready, 0);
            do_clear();
         end
         din = {$urandom, $urandom, $urandom, $urandom};
         for (int k = 0; k < NCH; k++) res[k*CW +: CW] = CW'($urandom_range(0, (1 << CW) - 1));
         core_resp = res;
         send_frame(din, lat);
         check("rnd_core_data", core_data, zext(din));
         check("rnd_out_s3", out_data, exp_frame(res, 3));
         check("rnd_out_s0", out_data_s0, exp_frame(res, 0));
         repeat ($urandom_range(0, 3)) tick();
         accept();
         check("rnd_count", sample_count, model_count);
         check("rnd_done", wav_done, model_done);
      end
      load_size = '0; model_load = 0;
      do_clear();

      // Reset while waiting on the core
      core_en = 1'b0;
      in_valid = 1'b1; in_data = rep_sw(16'h7777);
      tick();
      in_valid = 1'b0;
      tick();
      n_rst = 1'b0;
      #1;
      check("wrst_in_ready", in_ready, 0);
      check("wrst_core_start", core_start, 0);
      check("wrst_out_valid", out_valid, 0);
      check("wrst_out_data", out_data, 0);
      check("wrst_core_data", core_data, 0);
      check("wrst_count", sample_count, 0);
      check("wrst_done", wav_done, 0);
      tick();
      n_rst = 1'b1;
      model_count = 0; model_done = 1'b0;
      core_en = 1'b1;
      stray_req = 1'b1;
      tick();
      stray_req = 1'b0;
      tick(); tick();
      check("late_done_ignored", out_valid, 0);
      check("late_done_ready", in_ready, 1);
      echo = 1'b1;
      send_frame(rep_sw(16'h1234), lat);
      check("post_rst_out", out_data, rep_sw(16'h1234));
      accept();
      check("post_rst_count", sample_count, 8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
